// File: rtl/vram_banked.sv
// vram_banked: N independent byte lanes of single-port synchronous SRAM.
// Each lane has its own address, write strobe and read pipeline. A clear
// engine sweeps CLEAR_VAL through every address of every lane after reset
// (optional) or on request, and blocks port traffic while it runs.
module vram_banked #(
    parameter int ADDR_W = 15,
    parameter int LANE_W = 8,
    parameter int LANES = 2,
    parameter int OUT_REG = 0,
    parameter int RDW_MODE = 0,
    parameter int CLEAR_ON_RESET = 1,
    parameter logic [LANE_W-1:0] CLEAR_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [LANES*ADDR_W-1:0]    addr,
    input  logic [LANES-1:0]           wr_n,
    input  logic [LANES*LANE_W-1:0]    din,
    output logic [LANES*LANE_W-1:0]    dout,
    output logic [LANES-1:0]           dout_valid,
    input  logic                       clear_req,
    output logic                       busy
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        ST_READY = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t              state_reg;
    logic [ADDR_W-1:0]   cnt_reg;
    logic                busy_reg;
    logic                in_clear;

    assign in_clear = (state_reg == ST_CLEAR);
    assign busy     = busy_reg;

    // Clear-engine FSM: sweep counter, state and registered busy flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            cnt_reg   <= '0;
            busy_reg  <= (CLEAR_ON_RESET != 0);
        end else begin
            case (state_reg)
                ST_READY: begin
                    if (clear_req) begin
                        state_reg <= ST_CLEAR;
                        busy_reg  <= 1'b1;
                        cnt_reg   <= '0;
                    end
                end
                ST_CLEAR: begin
                    if (clear_req) begin
                        // A new request restarts the sweep from the bottom.
                        cnt_reg <= '0;
                    end else if (cnt_reg == ADDR_W'(DEPTH - 1)) begin
                        state_reg <= ST_READY;
                        busy_reg  <= 1'b0;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + ADDR_W'(1);
                    end
                end
                default: begin
                    state_reg <= ST_READY;
                    busy_reg  <= 1'b0;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [LANE_W-1:0] mem [DEPTH];
            logic [ADDR_W-1:0] lane_addr;
            logic [LANE_W-1:0] lane_din;
            logic              we;
            logic [ADDR_W-1:0] waddr;
            logic [LANE_W-1:0] wdata;
            logic              rd_take;
            logic              wt_take;
            logic [LANE_W-1:0] s1_data_reg;
            logic              s1_valid_reg;

            assign lane_addr = addr[gi*ADDR_W +: ADDR_W];
            assign lane_din  = din[gi*LANE_W +: LANE_W];

            // Port reads happen only in READY on read cycles; write-through
            // reuses the same stage so latency matches a read.
            assign rd_take = !in_clear && wr_n[gi];
            assign wt_take = !in_clear && !wr_n[gi] && (RDW_MODE != 0);

            // Write-port mux: the clear sweep owns the port while busy.
            always_comb begin
                we    = 1'b0;
                waddr = lane_addr;
                wdata = lane_din;
                if (in_clear) begin
                    we    = 1'b1;
                    waddr = cnt_reg;
                    wdata = CLEAR_VAL;
                end else if (!wr_n[gi]) begin
                    we = 1'b1;
                end
            end

            // Memory array write; contents are deliberately not reset.
            always_ff @(posedge clk) begin
                if (we) begin
                    mem[waddr] <= wdata;
                end
            end

            // Stage 1: registered read (or write-through data) plus strobe.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s1_data_reg  <= '0;
                    s1_valid_reg <= 1'b0;
                end else begin
                    s1_valid_reg <= rd_take || wt_take;
                    if (rd_take) begin
                        s1_data_reg <= mem[lane_addr];
                    end else if (wt_take) begin
                        s1_data_reg <= lane_din;
                    end
                end
            end

            if (OUT_REG != 0) begin : g_out_reg
                logic [LANE_W-1:0] s2_data_reg;
                logic              s2_valid_reg;

                // Stage 2: captures only valid stage-1 data, otherwise holds.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        s2_data_reg  <= '0;
                        s2_valid_reg <= 1'b0;
                    end else begin
                        s2_valid_reg <= s1_valid_reg;
                        if (s1_valid_reg) begin
                            s2_data_reg <= s1_data_reg;
                        end
                    end
                end

                assign dout[gi*LANE_W +: LANE_W] = s2_data_reg;
                assign dout_valid[gi]            = s2_valid_reg;
            end else begin : g_no_out_reg
                assign dout[gi*LANE_W +: LANE_W] = s1_data_reg;
                assign dout_valid[gi]            = s1_valid_reg;
            end
        end
    endgenerate

endmodule

// File: tb/tb_vram_banked.sv
// tb_vram_banked: drives two builds of vram_banked (2x8 bit, latency 1, hold
// on write; 4x16 bit, latency 2, write-through) with shared stimulus and
// checks both against a queue-based scoreboard fed by a behavioural model.
module tb_vram_banked;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear_req = 1'b0;
    logic [15:0] addr_bus = '0;
    logic [3:0]  wrn_bus = 4'hF;
    logic [63:0] din_bus = '0;

    logic [15:0] din0;
    logic [15:0] dout0;
    logic [1:0]  dv0;
    logic        busy0;
    logic [63:0] dout1;
    logic [3:0]  dv1;
    logic        busy1;

    assign din0 = {din_bus[23:16], din_bus[7:0]};

    always #5 clk = ~clk;

    vram_banked #(
        .ADDR_W(4), .LANE_W(8), .LANES(2), .OUT_REG(0), .RDW_MODE(0),
        .CLEAR_ON_RESET(1), .CLEAR_VAL(8'hA5)
    ) u0 (
        .clk(clk), .rst(rst), .addr(addr_bus[7:0]), .wr_n(wrn_bus[1:0]),
        .din(din0), .dout(dout0), .dout_valid(dv0), .clear_req(clear_req),
        .busy(busy0)
    );

    vram_banked #(
        .ADDR_W(4), .LANE_W(16), .LANES(4), .OUT_REG(1), .RDW_MODE(1),
        .CLEAR_ON_RESET(1), .CLEAR_VAL(16'h5A3C)
    ) u1 (
        .clk(clk), .rst(rst), .addr(addr_bus), .wr_n(wrn_bus),
        .din(din_bus), .dout(dout1), .dout_valid(dv1), .clear_req(clear_req),
        .busy(busy1)
    );

    typedef struct {
        logic [15:0] data;
        int          due;
    } exp_t;

    exp_t        sb_q[8][$];
    logic [15:0] ref_mem[2][4][DEPTH];
    logic [15:0] last_dout[2][4];
    int          cyc = 0;
    int          rem = 0;
    int          tests = 0;
    int          fails = 0;
    int          issued[2] = '{0, 0};
    int          seen[2] = '{0, 0};

    function automatic int nl(input int i);
        return (i == 0) ? 2 : 4;
    endfunction
    function automatic int lat(input int i);
        return (i == 0) ? 0 : 1;
    endfunction
    function automatic bit rdw(input int i);
        return (i != 0);
    endfunction
    function automatic logic [15:0] cv(input int i);
        return (i == 0) ? 16'h00A5 : 16'h5A3C;
    endfunction
    function automatic logic [15:0] dmask(input int i);
        return (i == 0) ? 16'h00FF : 16'hFFFF;
    endfunction
    function automatic logic [15:0] dut_dout(input int i, input int k);
        if (i == 0) return {8'h00, dout0[k*8 +: 8]};
        return dout1[k*16 +: 16];
    endfunction
    function automatic logic dut_valid(input int i, input int k);
        if (i == 0) return dv0[k];
        return dv1[k];
    endfunction
    function automatic logic dut_busy(input int i);
        return (i == 0) ? busy0 : busy1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: applies each edge's port operations by the rules
    // (reads return stored data, writes update storage, nothing while a
    // sweep is pending, everything becomes CLEAR_VAL when a sweep ends).
    logic [3:0]  m_a;
    logic [15:0] m_d;
    bit          m_was_clear;
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            rem = DEPTH;
            for (int j = 0; j < 8; j++) begin
                issued[j/4] -= sb_q[j].size();
                sb_q[j].delete();
            end
        end else begin
            m_was_clear = (rem > 0);
            if (!m_was_clear) begin
                for (int i = 0; i < 2; i++) begin
                    for (int k = 0; k < nl(i); k++) begin
                        m_a = addr_bus[k*4 +: 4];
                        m_d = din_bus[k*16 +: 16] & dmask(i);
                        if (wrn_bus[k]) begin
                            sb_q[i*4+k].push_back('{ref_mem[i][k][m_a], cyc + lat(i)});
                            issued[i]++;
                        end else begin
                            ref_mem[i][k][m_a] = m_d;
                            if (rdw(i)) begin
                                sb_q[i*4+k].push_back('{m_d, cyc + lat(i)});
                                issued[i]++;
                            end
                        end
                    end
                end
            end
            if (clear_req) begin
                rem = DEPTH;
            end else if (rem > 0) begin
                rem--;
                if (rem == 0) begin
                    for (int i = 0; i < 2; i++)
                        for (int k = 0; k < 4; k++)
                            for (int a = 0; a < DEPTH; a++)
                                ref_mem[i][k][a] = cv(i);
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever a lane strobes valid, checks
    // data and arrival cycle, busy, and that dout holds between strobes.
    exp_t mon_e;
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                check($sformatf("reset_busy[%0d]", i), {31'd0, dut_busy(i)}, 32'd1);
                for (int k = 0; k < nl(i); k++) begin
                    check($sformatf("reset_dout[%0d][%0d]", i, k),
                          {15'd0, dut_valid(i, k), dut_dout(i, k)}, 32'd0);
                    last_dout[i][k] = '0;
                end
            end else begin
                check($sformatf("busy[%0d]", i), {31'd0, dut_busy(i)}, {31'd0, rem > 0});
                for (int k = 0; k < nl(i); k++) begin
                    if (dut_valid(i, k)) begin
                        seen[i]++;
                        if (sb_q[i*4+k].size() == 0) begin
                            tests++;
                            fails++;
                            $display("FAIL unexpected_valid[%0d][%0d]: got valid data %h required no strobe (cycle %0d)",
                                     i, k, dut_dout(i, k), cyc);
                        end else begin
                            mon_e = sb_q[i*4+k].pop_front();
                            check($sformatf("data[%0d][%0d]", i, k), {16'd0, dut_dout(i, k)}, {16'd0, mon_e.data});
                            check($sformatf("latency[%0d][%0d]", i, k), cyc, mon_e.due);
                        end
                    end else begin
                        check($sformatf("hold[%0d][%0d]", i, k), {16'd0, dut_dout(i, k)}, {16'd0, last_dout[i][k]});
                        if (sb_q[i*4+k].size() > 0 && sb_q[i*4+k][0].due <= cyc) begin
                            mon_e = sb_q[i*4+k].pop_front();
                            tests++;
                            fails++;
                            $display("FAIL missing_valid[%0d][%0d]: got no strobe required data %h (cycle %0d)",
                                     i, k, mon_e.data, cyc);
                        end
                    end
                    last_dout[i][k] = dut_dout(i, k);
                end
            end
        end
    end

    // Stimulus helpers: drives are applied just after a falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_lane(input int k, input bit wr, input logic [3:0] a, input logic [15:0] d);
        wrn_bus[k]          = !wr;
        addr_bus[k*4 +: 4]  = a;
        din_bus[k*16 +: 16] = d;
    endtask

    task automatic idle_reads(input logic [3:0] a);
        for (int k = 0; k < 4; k++) set_lane(k, 1'b0, a, 16'h0000);
    endtask

    // Counts edges until busy drops; optionally pulses clear_req before
    // edge restart_at+1 of the count.
    task automatic wait_ready(input int restart_at, output int n);
        n = 0;
        while (n < 200) begin
            clear_req = (n == restart_at);
            @(posedge clk);
            #2;
            n++;
            if (!busy0) break;
            @(negedge clk);
        end
        @(negedge clk);
        clear_req = 1'b0;
        if (n >= 200) begin
            tests++;
            fails++;
            $display("FAIL wait_ready_timeout: got busy after %0d cycles required idle", n);
        end
    endtask

    int n;
    initial begin
        idle_reads(4'd0);
        repeat (3) tick();
        rst = 1'b0;
        wait_ready(-1, n);
        check("reset_sweep_len", n, 32'd16);

        // Every address reads back CLEAR_VAL after the reset sweep.
        for (int a = 0; a < DEPTH; a++) begin
            idle_reads(4'(a));
            tick();
        end

        // Write two lanes at [3], then read them back.
        set_lane(0, 1'b1, 4'd3, 16'h1212);
        set_lane(1, 1'b1, 4'd3, 16'h3434);
        tick();
        idle_reads(4'd3);
        tick();

        // Mixed: lane0 writes [5] while lane1 reads [5].
        set_lane(0, 1'b1, 4'd5, 16'h7777);
        set_lane(1, 1'b0, 4'd5, 16'h0000);
        set_lane(2, 1'b1, 4'd5, 16'hBEEF);
        tick();
        idle_reads(4'd5);
        tick();

        // Writes during a sweep are dropped; [2] reads CLEAR_VAL afterwards.
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        repeat (3) tick();
        for (int k = 0; k < 4; k++) set_lane(k, 1'b1, 4'd2, 16'hFFFF);
        tick();
        idle_reads(4'd2);
        wait_ready(-1, n);
        check("busy_write_sweep_len", n, 32'd12);
        idle_reads(4'd2);
        tick();

        // Restart at sweep cycle 10: 11 + 16 busy cycles.
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        wait_ready(10, n);
        check("restart_sweep_len", n, 32'd27);

        // Reset at sweep cycle 7: sweep restarts from 0 after release.
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        wait_ready(-1, n);
        check("reset_mid_sweep_len", n, 32'd16);

        // Random independent per-lane traffic.
        for (int c = 0; c < 10000; c++) begin
            for (int k = 0; k < 4; k++)
                set_lane(k, ($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)), 16'($urandom));
            clear_req = ($urandom_range(0, 1999) == 0);
            tick();
            clear_req = 1'b0;
        end

        // Drain through a sweep so no new reads are accepted.
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("valid_count[%0d]", i), seen[i], issued[i]);
            for (int k = 0; k < nl(i); k++)
                check($sformatf("queue_empty[%0d][%0d]", i, k), sb_q[i*4+k].size(), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
